// File: rtl/rle_serial_tx.sv
// Run-length serial transmitter: repeats bit_i on out_o for len_i cycles per accepted command.
// Optional completed-run counter on runs_o when RLE_TX_RUNCOUNT_EN is defined.
module rle_serial_tx #(
  parameter int unsigned LEN_W = 4
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic             bit_i,
  input  logic [LEN_W-1:0] len_i,
  output logic             out_o,
  output logic             out_valid_o,
`ifdef RLE_TX_RUNCOUNT_EN
  output logic [7:0]       runs_o,
`endif
  output logic             busy_o
);

  typedef enum logic [0:0] {StIdle, StSend} state_e;

  state_e           r_state;
  logic [LEN_W-1:0] r_rem;
  logic             r_cur_bit;
  logic             r_out_valid;
  logic             w_last;
  logic             w_accept;
  logic             w_load;

  assign w_last   = (r_state == StSend) && (r_rem == LEN_W'(1));
  assign ready_o  = (r_state == StIdle) || w_last;
  assign w_accept = valid_i && ready_o;
  assign w_load   = w_accept && (len_i != '0);

  assign out_o       = r_cur_bit;
  assign out_valid_o = r_out_valid;
  assign busy_o      = (r_state == StSend);

  // r_cur_bit is cleared whenever the line goes idle so out_o is a direct register output.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_state     <= StIdle;
      r_rem       <= '0;
      r_cur_bit   <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        StIdle: begin
          if (w_load) begin
            r_state     <= StSend;
            r_rem       <= len_i;
            r_cur_bit   <= bit_i;
            r_out_valid <= 1'b1;
          end else begin
            r_cur_bit   <= 1'b0;
            r_out_valid <= 1'b0;
          end
        end
        StSend: begin
          if (r_rem > LEN_W'(1)) begin
            r_rem <= r_rem - LEN_W'(1);
          end else if (w_load) begin
            r_rem       <= len_i;
            r_cur_bit   <= bit_i;
            r_out_valid <= 1'b1;
          end else begin
            r_state     <= StIdle;
            r_rem       <= '0;
            r_cur_bit   <= 1'b0;
            r_out_valid <= 1'b0;
          end
        end
        default: begin
          r_state     <= StIdle;
          r_rem       <= '0;
          r_cur_bit   <= 1'b0;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

`ifdef RLE_TX_RUNCOUNT_EN
  logic [7:0] r_runs;

  assign runs_o = r_runs;

  // Counts every run end, including ends that immediately reload a new run.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_runs <= 8'd0;
    end else if (w_last) begin
      r_runs <= r_runs + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_rle_serial_tx.sv
// Directed self-checking bench for rle_serial_tx; covers the runs_o counter when
// RLE_TX_RUNCOUNT_EN is defined.
module tb_rle_serial_tx;

  localparam int unsigned LEN_W = 4;

  logic             clk;
  logic             reset;
  logic             valid;
  logic             ready;
  logic             bit_in;
  logic [LEN_W-1:0] len;
  logic             out;
  logic             out_valid;
  logic             busy;
`ifdef RLE_TX_RUNCOUNT_EN
  logic [7:0]       runs;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  rle_serial_tx #(.LEN_W(LEN_W)) dut (
    .clk_i      (clk),
    .reset_i    (reset),
    .valid_i    (valid),
    .ready_o    (ready),
    .bit_i      (bit_in),
    .len_i      (len),
    .out_o      (out),
    .out_valid_o(out_valid),
`ifdef RLE_TX_RUNCOUNT_EN
    .runs_o     (runs),
`endif
    .busy_o     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Advance one edge and settle away from it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    valid = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // Accept (1,3) at edge k, expect output on k+1..k+3 and ready only on k+3.
  task automatic run_basic(input string pfx);
    valid  = 1'b1;
    bit_in = 1'b1;
    len    = 4'd3;
    check_eq({pfx, "_ready_idle"}, int'(ready), 1);
    tick();
    valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check_eq($sformatf("%s_ov_c%0d", pfx, i + 1), int'(out_valid), 1);
      check_eq($sformatf("%s_out_c%0d", pfx, i + 1), int'(out), 1);
      check_eq($sformatf("%s_busy_c%0d", pfx, i + 1), int'(busy), 1);
      check_eq($sformatf("%s_ready_c%0d", pfx, i + 1), int'(ready), (i == 2) ? 1 : 0);
      tick();
    end
    check_eq({pfx, "_ov_c4"}, int'(out_valid), 0);
    check_eq({pfx, "_busy_c4"}, int'(busy), 0);
    check_eq({pfx, "_ready_c4"}, int'(ready), 1);
  endtask

  initial begin
    int exp_seq [5];
    int n_ov;
    int n_busy;

    reset  = 1'b1;
    valid  = 1'b0;
    bit_in = 1'b0;
    len    = '0;
    #1;
    // A command offered during reset must be dropped.
    valid  = 1'b1;
    bit_in = 1'b1;
    len    = 4'd4;
    tick();
    tick();
    valid = 1'b0;
    check_eq("rst_ov", int'(out_valid), 0);
    check_eq("rst_out", int'(out), 0);
    check_eq("rst_busy", int'(busy), 0);
    check_eq("rst_ready", int'(ready), 1);
    reset = 1'b0;
    tick();
    check_eq("rst_drop_ov", int'(out_valid), 0);

    run_basic("s1");

    // Back-to-back (1,2) then (0,3) with valid held high.
    exp_seq = '{1, 1, 0, 0, 0};
    valid  = 1'b1;
    bit_in = 1'b1;
    len    = 4'd2;
    tick();
    bit_in = 1'b0;
    len    = 4'd3;
    for (int i = 0; i < 5; i++) begin
      check_eq($sformatf("b2b_ov_%0d", i), int'(out_valid), 1);
      check_eq($sformatf("b2b_out_%0d", i), int'(out), exp_seq[i]);
      if (i == 0) check_eq("b2b_hold_ready", int'(ready), 0);
      tick();
      if (i == 1) valid = 1'b0;
    end
    check_eq("b2b_ov_end", int'(out_valid), 0);
    check_eq("b2b_ready_end", int'(ready), 1);

    // Empty run is consumed silently, then a single-cycle run.
    valid  = 1'b1;
    bit_in = 1'b1;
    len    = 4'd0;
    tick();
    valid = 1'b0;
    check_eq("len0_ov", int'(out_valid), 0);
    check_eq("len0_busy", int'(busy), 0);
    check_eq("len0_ready", int'(ready), 1);
    tick();
    check_eq("len0_ov2", int'(out_valid), 0);
    valid  = 1'b1;
    bit_in = 1'b1;
    len    = 4'd1;
    tick();
    valid = 1'b0;
    check_eq("len1_ov", int'(out_valid), 1);
    check_eq("len1_out", int'(out), 1);
    check_eq("len1_ready", int'(ready), 1);
    tick();
    check_eq("len1_ov_end", int'(out_valid), 0);

    // Maximum length run.
    valid  = 1'b1;
    bit_in = 1'b0;
    len    = 4'd15;
    tick();
    valid  = 1'b0;
    n_ov   = 0;
    n_busy = 0;
    for (int i = 0; i < 20; i++) begin
      if (out_valid) n_ov++;
      if (busy) n_busy++;
      tick();
    end
    check_eq("max_ov_cycles", n_ov, 15);
    check_eq("max_busy_cycles", n_busy, 15);
    check_eq("max_ready_end", int'(ready), 1);

    // Reset on the second cycle of a length-5 run.
    valid  = 1'b1;
    bit_in = 1'b1;
    len    = 4'd5;
    tick();
    valid = 1'b0;
    check_eq("mid_ov_c1", int'(out_valid), 1);
    tick();
    check_eq("mid_ov_c2", int'(out_valid), 1);
    reset = 1'b1;
    tick();
    check_eq("mid_rst_ov", int'(out_valid), 0);
    check_eq("mid_rst_busy", int'(busy), 0);
    check_eq("mid_rst_ready", int'(ready), 1);
    reset = 1'b0;
    tick();
    check_eq("mid_post_ov", int'(out_valid), 0);
    run_basic("s5");

`ifdef RLE_TX_RUNCOUNT_EN
    do_reset();
    check_eq("runs_rst0", int'(runs), 0);
    valid  = 1'b1;
    bit_in = 1'b1;
    len    = 4'd1;
    repeat (257) tick();
    valid = 1'b0;
    tick();
    check_eq("runs_wrap", int'(runs), 1);
    check_eq("runs_idle_ov", int'(out_valid), 0);
    do_reset();
    check_eq("runs_rst1", int'(runs), 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/rle_serial_tx.md
Name: rle_serial_tx

Overview:
- Run-length serial transmitter: accepts (bit value, run length) commands over a valid/ready handshake and emits the bit value on a 1-bit serial line for that many consecutive cycles.
- Transmit-side counterpart of the team's Moore run counter, which consumes a serial bit stream and counts consecutive ones. This block produces that stream.
- Used as a stimulus source for the counter blocks and as the serialiser in the lab datapath.

Parameters:
- LEN_W, 4, width of run-length field; max run = 2^LEN_W - 1 cycles.

Ports:
- clk_i  input  1  clock. All state updates on the rising edge.
- reset_i  input  1  reset, synchronous, active-high.
- valid_i  input  1  command valid.
- ready_o  output  1  block can accept a command this cycle.
- bit_i  input  1  bit value to repeat.
- len_i  input  LEN_W  run length in cycles; 0 = empty run.
- out_o  output  1  serial data, registered.
- out_valid_o  output  1  out_o carries a run bit this cycle, registered.
- busy_o  output  1  high in SEND state.

Behaviour:
- One clock (clk_i). Reset is synchronous and active-high (reset_i).
- Reset takes priority over everything. State=IDLE, rem=0, out_o=0, out_valid_o=0, busy_o=0. Any command presented during reset is dropped.
- State machine is Moore with two states, IDLE and SEND. Registers: state, rem[LEN_W-1:0], cur_bit.
- ready_o is combinational from state only: ready_o = (state==IDLE) | (state==SEND & rem==1). It never depends on valid_i.
- A command is accepted at an edge where valid_i & ready_o is high.
- IDLE, accept with len_i>0:
  - next state SEND, rem=len_i, cur_bit=bit_i.
- IDLE, accept with len_i==0:
  - command is consumed, no output, state stays IDLE.
- IDLE, no accept: outputs stay out_valid_o=0, out_o=0.
- SEND, each cycle:
  - out_valid_o=1, out_o=cur_bit, busy_o=1.
  - at the edge, if rem>1 then rem=rem-1.
- SEND with rem==1 (last bit of the run):
  - accept with len_i>0: reload rem=len_i and cur_bit=bit_i, stay in SEND. The next run follows with no gap cycle (back-to-back).
  - accept with len_i==0: go to IDLE.
  - no accept: go to IDLE.
- Latency: a command accepted at edge k with length L gives out_valid_o=1 for exactly cycles k+1 through k+L, inclusive.
- Throughput: back-to-back runs produce a continuous out_valid_o. Runs of equal bit value concatenate on the wire.
- Width rules:
  - rem never underflows; the decrement is gated by rem>1.
  - len_i = 2^LEN_W - 1 is legal and gives the maximum run.
- Reset mid-run: output stops on the cycle after the reset edge. The remaining count is discarded.
- valid_i held high with ready_o low: the command is not consumed. The source must hold bit_i and len_i stable until accepted.

Optional Feature:
- Macro: RLE_TX_RUNCOUNT_EN.
- When defined:
  - adds output runs_o[7:0], a count of completed runs with len>0.
  - increments on the edge where SEND ends a run (rem==1), whether the next state is IDLE or SEND with a reload.
  - wraps 255 -> 0.
  - reset value 0.
- When undefined: port and counter are absent. All other behaviour is identical.

Test Plan:
- Reset, then accept (bit_i=1, len_i=3) at edge k -> out_valid_o=1 and out_o=1 on cycles k+1..k+3; out_valid_o=0 at k+4; ready_o=1 in IDLE and on cycle k+3 only.
- Back-to-back (1,2) then (0,3), valid_i held continuously -> out_o sequence 1,1,0,0,0 with out_valid_o high for 5 straight cycles, then low.
- len_i=0 while in IDLE -> command consumed, out_valid_o stays 0, next command (1,1) gives a single 1 one cycle after its acceptance.
- len_i=15 with LEN_W=4 -> exactly 15 cycles of out_valid_o=1, busy_o high for 15 cycles, no wrap.
- reset_i=1 on the second cycle of a len 5 run -> out_valid_o=0, busy_o=0, ready_o=1 on the cycle after the reset edge; a new command after reset behaves as in scenario 1.
- With RLE_TX_RUNCOUNT_EN: 257 runs of (1,1) -> runs_o=1 after wrap; reset -> runs_o=0.
